// File: rtl/index_mask_builder.sv
// Rebuilds a DATA_W-bit mask from a framed stream of bit indices, held on the output until accepted.
// Optional duplicate-index detection is compiled in with `INDEX_MASK_BUILDER_DUP_DETECT_EN.
module index_mask_builder #(
  parameter int IDX_W = 3,
  localparam int DATA_W = 1 << IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W:0]    out_count,
  output logic              out_dup
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready depends only on state.
  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic              accept;

  function automatic logic [IDX_W:0] popcount(input logic [DATA_W-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + {{IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (in_valid && in_last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == OUT);
  end

  assign accept   = in_valid && in_ready;
  assign acc_next = acc | (DATA_W'(1) << in_index);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (accept) begin
      if (in_last) begin
        out_data  <= acc_next;
        out_count <= popcount(acc_next);
        acc       <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

`ifdef INDEX_MASK_BUILDER_DUP_DETECT_EN
  logic dup_flag;
  logic out_dup_q;
  logic is_dup;

  // A beat is a duplicate when its bit is already set in the running mask.
  assign is_dup = acc[in_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      dup_flag  <= 1'b0;
      out_dup_q <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_dup_q <= dup_flag | is_dup;
        dup_flag  <= 1'b0;
      end else begin
        dup_flag <= dup_flag | is_dup;
      end
    end
  end

  assign out_dup = out_dup_q;
`else
  assign out_dup = 1'b0;
`endif

endmodule

// File: tb/tb_index_mask_builder.sv
// Bench for index_mask_builder: table-driven frames, hand-written reset sequences and
// randomized frames checked against a set-based reference model.
module tb_index_mask_builder;

`ifdef INDEX_MASK_BUILDER_DUP_DETECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_index = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_dup;

  int n_vec = 0;
  int n_err = 0;

  int          beats[$];
  logic [12:0] exp_q[$];

  typedef struct {
    int          len;
    logic [23:0] idxs;
    int          gap;
    int          hold;
    logic [7:0]  data;
    logic [3:0]  count;
    logic        dup;
  } vec_t;

  vec_t tbl[7];

  index_mask_builder #(.IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [23:0] idxs, input int gap,
                              input int hold, input logic [7:0] data,
                              input logic [3:0] count, input logic dup);
    vec_t v;
    v.len = len; v.idxs = idxs; v.gap = gap; v.hold = hold;
    v.data = data; v.count = count; v.dup = dup;
    return v;
  endfunction

  // Reference: the mask is the set of indices seen; duplicates are any repeat within the frame.
  function automatic logic [12:0] model();
    bit   seen[8];
    int   total;
    int   cnt;
    logic dup;
    total = 0; cnt = 0; dup = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (beats[i]) begin
      if (seen[beats[i]]) dup = 1'b1;
      else begin
        seen[beats[i]] = 1'b1;
        cnt++;
        total += 2 ** beats[i];
      end
    end
    return {dup & DUP_EN, 4'(cnt), 8'(total)};
  endfunction

  task automatic send_beat(input int idx, input logic last);
    int b;
    in_valid = 1'b1;
    in_index = 3'(idx);
    in_last  = last;
    b = 0;
    while (!in_ready && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int gap, input int hold);
    logic [12:0] e;
    foreach (beats[i]) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      send_beat(beats[i], i == beats.size() - 1);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check("latency_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(e[7:0]));
    check("out_count", 32'(out_count), 32'(e[11:8]));
    check("out_dup", 32'(out_dup), 32'(e[12]));
    check("in_ready_out", 32'(in_ready), 32'd0);
    repeat (hold) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = 3'($urandom_range(0, 7));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_data", 32'(out_data), 32'(e[7:0]));
      check("hold_count", 32'(out_count), 32'(e[11:8]));
      check("hold_dup", 32'(out_dup), 32'(e[12]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = mk(1, {21'd0, 3'd7},                     0, 0, 8'h80, 4'd1, 1'b0);
    tbl[1] = mk(3, {15'd0, 3'd7, 3'd5, 3'd2},          1, 0, 8'hA4, 4'd3, 1'b0);
    tbl[2] = mk(8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 0, 3, 8'hFF, 4'd8, 1'b0);
    tbl[3] = mk(1, {21'd0, 3'd6},                     0, 0, 8'h40, 4'd1, 1'b0);
    tbl[4] = mk(2, {18'd0, 3'd3, 3'd3},                0, 0, 8'h08, 4'd1, 1'b1);
    tbl[5] = mk(3, {15'd0, 3'd2, 3'd1, 3'd1},          0, 1, 8'h06, 4'd2, 1'b1);
    tbl[6] = mk(2, {18'd0, 3'd0, 3'd4},                2, 0, 8'h11, 4'd2, 1'b0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_dup", 32'(out_dup), 32'd0);

    for (int t = 0; t < 7; t++) begin
      beats.delete();
      for (int i = 0; i < tbl[t].len; i++) beats.push_back(int'(tbl[t].idxs[3*i +: 3]));
      exp_q.push_back({tbl[t].dup & DUP_EN, tbl[t].count, tbl[t].data});
      run_frame(tbl[t].gap, tbl[t].hold);
    end

    // Reset mid-frame; the beat offered alongside rst must be discarded too.
    send_beat(1, 1'b0);
    send_beat(4, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_index = 3'd2; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    beats.delete();
    beats.push_back(0);
    exp_q.push_back({1'b0, 4'd1, 8'h01});
    run_frame(0, 0);

    // Reset while a mask is pending drops it.
    send_beat(5, 1'b1);
    @(negedge clk);
    check("outrst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("outrst_valid", 32'(out_valid), 32'd0);
    check("outrst_data", 32'(out_data), 32'd0);
    check("outrst_count", 32'(out_count), 32'd0);
    check("outrst_ready", 32'(in_ready), 32'd1);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 12);
      beats.delete();
      for (int i = 0; i < len; i++) beats.push_back($urandom_range(0, 7));
      exp_q.push_back(model());
      run_frame($urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
